// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encodings and
// default reset/increment constants.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_VREP   = 2'd1,
    ST_HALTED = 2'd2
  } pcs_state_t;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_INC      = 16'd2;

endpackage

// File: rtl/pc_sequencer_pcadder.sv
// Shared 16-bit PC adder, C = A + B, wrapping modulo 2^16 with no carry out.
module pcadder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_c
);

  assign o_c = i_a + i_b;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences increment/branch/jump, vector-repeat hold
// and halt, driving the shared pcadder for all relative updates.
//
// state   | meaning
// RUN     | normal fetch; pc advances by INC, branch offset or jump target
// VREP    | pc held while vidx walks 0..vlen_q-1 over vector elements
// HALTED  | everything frozen until RST
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] INC      = DEF_INC,
  parameter int          VLEN_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump,
  input  logic [15:0]       jump_addr,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              vstart,
  input  logic [VLEN_W-1:0] vlen,
  output logic [15:0]       pc,
  output logic [15:0]       pc_next,
  output logic              vbusy,
  output logic [VLEN_W-1:0] vidx,
  output logic              halted
);

  pcs_state_t        r_state;
  logic [15:0]       r_pc;
  logic [VLEN_W-1:0] r_vidx;
  logic [VLEN_W-1:0] r_vlen_q;

  pcs_state_t        w_state_nxt;
  logic [15:0]       w_pc_nxt;
  logic [VLEN_W-1:0] w_vidx_nxt;
  logic [VLEN_W-1:0] w_vlen_nxt;
  logic [15:0]       w_add_b;
  logic [15:0]       w_sum;
  logic              w_last_elem;

  pcadder u_pcadder (
    .i_a (r_pc),
    .i_b (w_add_b),
    .o_c (w_sum)
  );

  assign w_last_elem = (r_vidx == (r_vlen_q - VLEN_W'(1)));

  // Only a branch accepted in RUN swaps the second operand away from INC.
  always_comb begin
    w_add_b = INC;
    if (r_state == ST_RUN && !halt && !stall && !jump && br_taken)
      w_add_b = br_offset;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vidx_nxt  = r_vidx;
    w_vlen_nxt  = r_vlen_q;
    unique case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (stall) begin
          w_state_nxt = ST_RUN;
        end else if (jump) begin
          w_pc_nxt = jump_addr;
        end else if (br_taken) begin
          w_pc_nxt = w_sum;
        end else if (vstart && vlen != '0) begin
          w_vlen_nxt  = vlen;
          w_vidx_nxt  = '0;
          w_state_nxt = ST_VREP;
        end else begin
          w_pc_nxt = w_sum;
        end
      end
      ST_VREP: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
          w_vidx_nxt  = '0;
        end else if (stall) begin
          w_state_nxt = ST_VREP;
        end else if (w_last_elem) begin
          w_pc_nxt    = w_sum;
          w_vidx_nxt  = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_vidx_nxt = r_vidx + VLEN_W'(1);
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_vidx   <= '0;
      r_vlen_q <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_vidx   <= w_vidx_nxt;
      r_vlen_q <= w_vlen_nxt;
    end
  end

  // pc_next reflects reset too, so it always matches pc one edge later.
  assign pc_next = RST ? RESET_PC : w_pc_nxt;
  assign pc      = r_pc;
  assign vidx    = r_vidx;
  assign vbusy   = (r_state == ST_VREP);
  assign halted  = (r_state == ST_HALTED);

endmodule
